safe_lock_seq_param: RTL and testbench
======================================

// Module: safe_lock_seq_param
// PURPOSE
//  Parametrised keypad/code-entry safe lock FSM, the successor to the fixed 4-bit serial lock.
//  Accepts CODE_LEN multi-bit digits and judges the code only after the full entry, so no early error leaks.
//  Adds failed-attempt lockout, timed unlock and in-field code reprogramming.
//  Sits after the debouncer/edge detector and feeds the 7-seg display driver via state_o.
// PARAMETERS
//  CODE_LEN       4        number of digits per code (>=1)
//  DIGIT_W        4        bits per digit
//  CODE_RESET     16'h1011 code loaded at reset, CODE_LEN*DIGIT_W bits; first digit in MS field
//  MAX_FAILS      3        consecutive wrong codes that trigger lockout (>=1)
//  LOCKOUT_CYC    1000     clk cycles spent in LOCKOUT
//  UNLOCK_CYC     500      clk cycles unlocked stays high
// PORTS
//  clk          in   1                       system clock, all logic posedge
//  reset_n      in   1                       async active-low reset
//  digit_valid  in   1                       1-cycle strobe, digit_in valid (pre-debounced)
//  digit_in     in   DIGIT_W                 entered digit
//  clear        in   1                       abort current entry/programming
//  program_req  in   1                       request code change (honoured only in UNLOCK)
//  unlocked     out  1                       high throughout UNLOCK
//  locked_out   out  1                       high throughout LOCKOUT
//  error        out  1                       1-cycle pulse on wrong complete code
//  fail_cnt     out  $clog2(MAX_FAILS+1)     consecutive failures so far
//  entry_idx    out  $clog2(CODE_LEN+1)      digits accepted in current entry
//  state_o      out  3                       0 ENTRY,1 UNLOCK,2 ERROR,3 LOCKOUT,4 PROGRAM
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: state=ENTRY, code reg=CODE_RESET, entry_idx=0, mismatch=0, fail_cnt=0, timer=0.
//   All outputs 0 (state_o=0). Reset mid-operation aborts everything, including PROGRAM.
//  Digit k (0-based) is compared with code[(CODE_LEN-k)*DIGIT_W-1 -: DIGIT_W]. All outputs are registered.
//  ENTRY: on digit_valid, entry_idx++ and mismatch|=(digit!=expected).
//   The CODE_LEN-th digit is judged in the same edge using the current digit's compare result.
//   On a match, go to UNLOCK: fail_cnt<=0, timer<=0.
//   On a mismatch with fail_cnt+1==MAX_FAILS, go to LOCKOUT and set fail_cnt<=MAX_FAILS.
//   On any other mismatch, go to ERROR and increment fail_cnt.
//   Every judged attempt clears entry_idx and mismatch.
//  clear (any state except LOCKOUT/UNLOCK) zeroes entry_idx and mismatch. fail_cnt is unchanged.
//   clear has priority over a same-cycle digit_valid, whose digit is dropped.
//  ERROR: lasts exactly 1 cycle with error=1, then ENTRY. digit_valid in ERROR is ignored.
//  UNLOCK: unlocked=1 for UNLOCK_CYC cycles (timer counts 0..UNLOCK_CYC-1), then ENTRY.
//   digit_valid is ignored.
//   program_req goes to PROGRAM next edge, taking priority over timer expiry in the same cycle.
//  PROGRAM: unlocked=0. Each digit_valid shifts into the shadow reg, entry_idx++.
//   On the CODE_LEN-th digit, the code reg takes the new value and the block returns to ENTRY.
//   clear returns to ENTRY with the code unchanged. There is no timeout in PROGRAM.
//  LOCKOUT: locked_out=1 for LOCKOUT_CYC cycles. All inputs are ignored.
//   After LOCKOUT, return to ENTRY with fail_cnt<=0.
//  Timer width is $clog2(max(LOCKOUT_CYC,UNLOCK_CYC)+1). The timer resets on every state entry.
//  Unused state encodings (5-7) recover to ENTRY on the next edge with fail_cnt preserved.
// TESTING
//  Reset, then digits 1,0,1,1 (defaults, DIGIT_W=4) -> unlocked=1 next cycle for 500 cycles.
//   state_o=1, then 0.
//  Digits 1,0,0,1 -> error pulses 1 cycle, fail_cnt=1, no error before the 4th digit.
//   Entering a correct code afterwards clears fail_cnt to 0.
//  Three wrong codes back-to-back -> third gives locked_out=1 for 1000 cycles and error stays 0.
//   Digits entered during lockout are ignored. Afterwards fail_cnt=0.
//  Unlock, program_req, digits 9,8,7,6 -> the old code 1011 is now rejected.
//   9876 unlocks. clear mid-program keeps the old code.
//  Digits 1,0 then clear asserted together with digit_valid -> entry_idx=0.
//   Then 1,0,1,1 unlocks.
//  Assert reset_n low mid-entry and mid-PROGRAM -> all outputs 0 immediately.
//   The code reverts to 1011.

Source files
------------

// File: rtl/safe_lock_seq_param.sv
// Parametrised code-entry safe lock: judges a full CODE_LEN-digit entry, then unlocks, errors or locks out.
// Supports timed unlock, failed-attempt lockout and reprogramming of the code while unlocked.
module safe_lock_seq_param #(
    parameter int CODE_LEN    = 4,
    parameter int DIGIT_W     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE_RESET = 16'h1011,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int UNLOCK_CYC  = 500,
    localparam int FC_W       = $clog2(MAX_FAILS+1),
    localparam int IDX_W      = $clog2(CODE_LEN+1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               clear,
    input  logic               program_req,
    output logic               unlocked,
    output logic               locked_out,
    output logic               error,
    output logic [FC_W-1:0]    fail_cnt,
    output logic [IDX_W-1:0]   entry_idx,
    output logic [2:0]         state_o
);
    localparam int CODE_W  = CODE_LEN*DIGIT_W;
    localparam int TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX+1);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_UNLOCK  = 3'd1,
        ST_ERROR   = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROGRAM = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mism_q, mism_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;
    logic                error_q, error_d;

    logic [CODE_W-1:0]   code_sh;
    logic [DIGIT_W-1:0]  exp_digit;
    logic [CODE_W-1:0]   shifted;
    logic                last_digit;
    logic                digit_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_ENTRY;
            code_q       <= CODE_RESET;
            shadow_q     <= '0;
            idx_q        <= '0;
            mism_q       <= 1'b0;
            fc_q         <= '0;
            tmr_q        <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            mism_q       <= mism_d;
            fc_q         <= fc_d;
            tmr_q        <= tmr_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
            error_q      <= error_d;
        end
    end

    // Digit k is compared against the k-th field counted from the MS end of the code.
    always_comb begin
        code_sh    = code_q >> (DIGIT_W * (CODE_LEN - 1 - int'(idx_q)));
        exp_digit  = code_sh[DIGIT_W-1:0];
        digit_bad  = (digit_in != exp_digit);
        last_digit = (idx_q == IDX_W'(CODE_LEN-1));
        shifted    = CODE_W'({shadow_q, digit_in});
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        fc_d     = fc_q;
        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (digit_valid) begin
                    if (last_digit) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!(mism_q || digit_bad)) begin
                            state_d = ST_UNLOCK;
                            fc_d    = '0;
                        end else if (fc_q == FC_W'(MAX_FAILS-1)) begin
                            state_d = ST_LOCKOUT;
                            fc_d    = FC_W'(MAX_FAILS);
                        end else begin
                            state_d = ST_ERROR;
                            fc_d    = fc_q + 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        mism_d = mism_q | digit_bad;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
                mism_d  = 1'b0;
            end
            ST_UNLOCK: begin
                if (program_req) begin
                    state_d = ST_PROGRAM;
                    idx_d   = '0;
                end else if (tmr_q == TMR_W'(UNLOCK_CYC-1)) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_PROGRAM: begin
                if (clear) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end else if (digit_valid) begin
                    shadow_d = shifted;
                    if (last_digit) begin
                        code_d  = shifted;
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == TMR_W'(LOCKOUT_CYC-1)) begin
                    state_d = ST_ENTRY;
                    fc_d    = '0;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
                mism_d  = 1'b0;
            end
        endcase

        // Timer restarts from zero whenever the state changes.
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q == ST_UNLOCK || state_q == ST_LOCKOUT) begin
            tmr_d = tmr_q + 1'b1;
        end else begin
            tmr_d = '0;
        end
    end

    always_comb begin
        unlocked_d   = (state_d == ST_UNLOCK);
        locked_out_d = (state_d == ST_LOCKOUT);
        error_d      = (state_d == ST_ERROR);
    end

    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign error      = error_q;
    assign fail_cnt   = fc_q;
    assign entry_idx  = idx_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_safe_lock_seq_param.sv
// Scoreboard bench for safe_lock_seq_param: stimulus pushes expected state transitions, a monitor checks them.
module tb_safe_lock_seq_param;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic       clear;
    logic       program_req;
    logic       unlocked;
    logic       locked_out;
    logic       error;
    logic [1:0] fail_cnt;
    logic [2:0] entry_idx;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st;
        int fc;
        int dwell;
    } exp_t;

    exp_t sb[$];

    safe_lock_seq_param dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .clear       (clear),
        .program_req (program_req),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .error       (error),
        .fail_cnt    (fail_cnt),
        .entry_idx   (entry_idx),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void expect_tr(input int st, input int fc, input int dwell);
        exp_t e;
        e.st = st;
        e.fc = fc;
        e.dwell = dwell;
        sb.push_back(e);
    endfunction

    // Monitor: every observed state change must match the next expected transition.
    initial begin : monitor
        int   prev_st;
        int   last_cyc;
        int   cyc;
        exp_t e;
        prev_st  = 0;
        last_cyc = 0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (int'(state_o) != prev_st) begin
                if (sb.size() == 0) begin
                    chk("unexpected_transition_to", int'(state_o), prev_st);
                end else begin
                    e = sb.pop_front();
                    chk("sb_state", int'(state_o), e.st);
                    chk("sb_fail_cnt", int'(fail_cnt), e.fc);
                    chk("sb_unlocked", int'(unlocked), (e.st == 1) ? 1 : 0);
                    chk("sb_error", int'(error), (e.st == 2) ? 1 : 0);
                    chk("sb_locked_out", int'(locked_out), (e.st == 3) ? 1 : 0);
                    if (e.dwell >= 0) chk("sb_dwell", cyc - last_cyc, e.dwell);
                end
                prev_st  = int'(state_o);
                last_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; the digit is captured at the following posedge.
    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [15:0] c);
        send_digit(c[15:12]);
        send_digit(c[11:8]);
        send_digit(c[7:4]);
        send_digit(c[3:0]);
    endtask

    task automatic wait_sb(input int upto, input int budget, input string nm);
        int n = 0;
        while (sb.size() > upto && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (sb.size() > upto) ? sb.size() : upto, upto);
        if (sb.size() > upto) sb.delete();
    endtask

    task automatic pulse_program;
        program_req = 1'b1;
        @(negedge clk);
        program_req = 1'b0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin : stim
        reset_n     = 1'b0;
        digit_valid = 1'b0;
        digit_in    = '0;
        clear       = 1'b0;
        program_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(state_o), 0);
        chk("reset_flags", int'({unlocked, locked_out, error}), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        chk("reset_entry_idx", int'(entry_idx), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Correct default code unlocks for 500 cycles.
        expect_tr(1, 0, -1);
        expect_tr(0, 0, 500);
        send_digit(4'h1);
        send_digit(4'h0);
        send_digit(4'h1);
        chk("entry_idx_after_3", int'(entry_idx), 3);
        send_digit(4'h1);
        wait_sb(0, 600, "unlock_default");

        // clear together with a digit drops the digit and restarts the entry.
        send_digit(4'h1);
        send_digit(4'h0);
        chk("entry_idx_before_clear", int'(entry_idx), 2);
        clear = 1'b1;
        send_digit(4'h1);
        clear = 1'b0;
        chk("entry_idx_after_clear", int'(entry_idx), 0);
        expect_tr(1, 0, -1);
        expect_tr(0, 0, 500);
        send_code(16'h1011);
        wait_sb(0, 600, "unlock_after_clear");

        // Wrong code: single error pulse, digit during ERROR ignored, then correct code clears fail_cnt.
        expect_tr(2, 1, -1);
        expect_tr(0, 1, 1);
        expect_tr(1, 0, -1);
        expect_tr(0, 0, 500);
        send_code(16'h1001);
        send_digit(4'h1);
        send_code(16'h1011);
        wait_sb(0, 600, "error_then_unlock");

        // Three wrong codes: lockout for 1000 cycles, inputs ignored, fail_cnt returns to 0.
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                expect_tr(2, i + 1, -1);
                expect_tr(0, i + 1, 1);
                send_code(16'h2222);
                wait_sb(0, 10, "wrong_attempt");
            end else begin
                expect_tr(3, 3, -1);
                expect_tr(0, 0, 1000);
                send_code(16'h2222);
                send_code(16'h1011);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                wait_sb(0, 1200, "lockout");
            end
        end

        // Reprogram to 9876 while unlocked.
        expect_tr(1, 0, -1);
        expect_tr(4, 0, -1);
        expect_tr(0, 0, -1);
        send_code(16'h1011);
        wait_sb(2, 20, "unlock_before_program");
        pulse_program();
        send_code(16'h9876);
        wait_sb(0, 20, "program_9876");

        expect_tr(2, 1, -1);
        expect_tr(0, 1, 1);
        send_code(16'h1011);
        wait_sb(0, 10, "old_code_rejected");

        // clear mid-program keeps 9876.
        expect_tr(1, 0, -1);
        expect_tr(4, 0, -1);
        expect_tr(0, 0, -1);
        send_code(16'h9876);
        wait_sb(2, 20, "unlock_new_code");
        pulse_program();
        send_digit(4'h1);
        send_digit(4'h2);
        pulse_clear();
        wait_sb(0, 20, "program_abort");

        expect_tr(1, 0, -1);
        expect_tr(0, 0, 500);
        send_code(16'h9876);
        wait_sb(0, 600, "code_kept_after_clear");

        // Reset mid-PROGRAM: outputs drop at once.
        expect_tr(1, 0, -1);
        expect_tr(4, 0, -1);
        expect_tr(0, 0, -1);
        send_code(16'h9876);
        wait_sb(2, 20, "unlock_before_reset");
        pulse_program();
        send_digit(4'h5);
        chk("prog_entry_idx", int'(entry_idx), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_prog_state", int'(state_o), 0);
        chk("rst_prog_entry_idx", int'(entry_idx), 0);
        chk("rst_prog_flags", int'({unlocked, locked_out, error}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_sb(0, 10, "reset_mid_program");

        // Reset mid-entry with a pending failure count.
        expect_tr(2, 1, -1);
        expect_tr(0, 1, 1);
        send_code(16'h2222);
        wait_sb(0, 10, "fail_before_reset");
        send_digit(4'h1);
        send_digit(4'h0);
        chk("entry_idx_before_reset", int'(entry_idx), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_entry_idx", int'(entry_idx), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_entry_state", int'(state_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Code reverted to the reset value.
        expect_tr(1, 0, -1);
        expect_tr(0, 0, 500);
        send_code(16'h1011);
        wait_sb(0, 600, "code_reverted");

        repeat (5) @(negedge clk);
        chk("sb_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
